// File: rtl/stopwatch_up_pkg.sv
// Shared types and constants for the count-up BCD seconds stopwatch.
package stopwatch_up_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LED_ALL = 16'hFFFF;
  localparam logic [15:0] LED_RUN = 16'h0001;
  localparam logic [15:0] LED_LAP = 16'h0002;
  localparam logic [15:0] LED_OFF = 16'h0000;

  // Next value of a single BCD digit counting 0..9.
  function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_up_bcd_up.sv
// One BCD digit that counts up on inc and wraps to 0 after reaching limit.
module bcd_up
  import stopwatch_up_pkg::*;
(
  input  logic               clk,
  input  logic               rst_h,
  input  logic               clr,
  input  logic               inc,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;
  logic               wrap;

  assign wrap  = inc && (q_q == limit);
  assign carry = wrap;
  assign q     = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = wrap ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/stopwatch_up.sv
// Count-up BCD seconds stopwatch with start/pause and lap/clear buttons.
// Optional lap-hold display is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_up
  import stopwatch_up_pkg::*;
#(
  parameter logic [3:0] LIMIT_TENS = 4'd3,
  parameter logic [3:0] LIMIT_ONES = 4'd0
) (
  input  logic         clk,
  input  logic         rst_h,
  input  logic         tick_1hz,
  input  logic         start_pulse,
  input  logic         lap_pulse,
  output logic [3:0]   value1,
  output logic [3:0]   value0,
  output logic         running,
  output logic         done,
  output logic [15:0]  led,
  output state_t       state_dbg
);

  // Handshake: tick_1hz, start_pulse and lap_pulse are one-clk-wide
  // strobes with no ready/back-pressure; each is consumed on the edge it is seen.
  state_t             state_q;
  logic               running_q;
  logic               done_q;
  logic [15:0]        led_q;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] tens_q;
  logic [DIGIT_W-1:0] ones_d;
  logic [DIGIT_W-1:0] tens_d;
  logic               ones_carry;
  logic               tens_carry_unused;
  logic               run_tick;
  logic               hit;
  logic               clr;

  assign run_tick = (state_q == ST_RUN) && tick_1hz;

  // Look-ahead of the incremented count, so DONE is entered on the same edge.
  assign ones_d = bcd_next(ones_q);
  assign tens_d = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
  assign hit    = run_tick && (tens_d == LIMIT_TENS) && (ones_d == LIMIT_ONES);

  assign clr = ((state_q == ST_DONE)  && start_pulse) ||
               ((state_q == ST_PAUSE) && lap_pulse && !start_pulse);

  bcd_up u_ones (
    .clk   (clk),
    .rst_h (rst_h),
    .clr   (clr),
    .inc   (run_tick),
    .limit (4'd9),
    .q     (ones_q),
    .carry (ones_carry)
  );

  bcd_up u_tens (
    .clk   (clk),
    .rst_h (rst_h),
    .clr   (clr),
    .inc   (ones_carry),
    .limit (LIMIT_TENS),
    .q     (tens_q),
    .carry (tens_carry_unused)
  );

`ifdef STOPWATCH_LAP_EN
  logic               hold_q;
  logic [DIGIT_W-1:0] snap1_q;
  logic [DIGIT_W-1:0] snap0_q;
`endif

  always_ff @(posedge clk) begin
    if (rst_h) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= LED_OFF;
`ifdef STOPWATCH_LAP_EN
      hold_q    <= 1'b0;
      snap1_q   <= '0;
      snap0_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            led_q     <= LED_RUN;
          end
        end
        ST_RUN: begin
          if (hit) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            led_q     <= LED_ALL;
`ifdef STOPWATCH_LAP_EN
            hold_q    <= 1'b0;
`endif
          end else if (start_pulse) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
            led_q     <= LED_OFF;
`ifdef STOPWATCH_LAP_EN
            hold_q    <= 1'b0;
`endif
          end
`ifdef STOPWATCH_LAP_EN
          else if (lap_pulse) begin
            hold_q  <= !hold_q;
            snap1_q <= tens_q;
            snap0_q <= ones_q;
            led_q   <= hold_q ? LED_RUN : (LED_RUN | LED_LAP);
          end
`endif
        end
        ST_PAUSE: begin
          if (start_pulse) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            led_q     <= LED_RUN;
          end else if (lap_pulse) begin
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          if (start_pulse) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            led_q   <= LED_OFF;
          end
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  assign value1 = hold_q ? snap1_q : tens_q;
  assign value0 = hold_q ? snap0_q : ones_q;
`else
  assign value1 = tens_q;
  assign value0 = ones_q;
`endif

  assign running   = running_q;
  assign done      = done_q;
  assign led       = led_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_up.sv
// Self-checking bench for stopwatch_up: decimal reference model feeding an
// expected-value queue, plus directed checks at the interesting points.
module tb_stopwatch_up;
  import stopwatch_up_pkg::*;

  localparam int LIMIT = 30;

  logic        clk = 1'b0;
  logic        rst_h = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        start_pulse = 1'b0;
  logic        lap_pulse = 1'b0;
  logic [3:0]  value1;
  logic [3:0]  value0;
  logic        running;
  logic        done;
  logic [15:0] led;
  state_t      state_dbg;

  stopwatch_up #(.LIMIT_TENS(4'd3), .LIMIT_ONES(4'd0)) dut (
    .clk         (clk),
    .rst_h       (rst_h),
    .tick_1hz    (tick_1hz),
    .start_pulse (start_pulse),
    .lap_pulse   (lap_pulse),
    .value1      (value1),
    .value0      (value0),
    .running     (running),
    .done        (done),
    .led         (led),
    .state_dbg   (state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // scoreboard: {state[1:0], done, running, led[15:0], value1, value0}
  logic [27:0] exp_q[$];
  int checks_n = 0;
  int errors_n = 0;

  // reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE, count kept as plain integer
  int m_state = 0;
  int m_cnt   = 0;
  int m_snap  = 0;
  bit m_hold  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [27:0] model_obs();
    int disp;
    logic [15:0] l;
    logic [3:0] d1, d0;
    logic [1:0] st;
    disp = m_hold ? m_snap : m_cnt;
    d1 = 4'(disp / 10);
    d0 = 4'(disp % 10);
    st = 2'(m_state);
    case (m_state)
      1: l = m_hold ? 16'h0003 : 16'h0001;
      3: l = 16'hFFFF;
      default: l = 16'h0000;
    endcase
    return {st, (m_state == 3), (m_state == 1), l, d1, d0};
  endfunction

  task automatic model_step(input bit s, input bit l, input bit t, input bit r);
    int nxt;
    if (r) begin
      m_state = 0; m_cnt = 0; m_hold = 0; m_snap = 0;
      return;
    end
    case (m_state)
      0: if (s) m_state = 1;
      1: begin
        nxt = t ? m_cnt + 1 : m_cnt;
        if (t && nxt == LIMIT) begin
          m_state = 3; m_hold = 0;
        end else if (s) begin
          m_state = 2; m_hold = 0;
        end
`ifdef STOPWATCH_LAP_EN
        else if (l) begin
          if (!m_hold) m_snap = m_cnt;
          m_hold = !m_hold;
        end
`endif
        m_cnt = nxt;
      end
      2: begin
        if (s) m_state = 1;
        else if (l) begin m_state = 0; m_cnt = 0; end
      end
      default: if (s) begin m_state = 0; m_cnt = 0; end
    endcase
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input bit s, input bit l, input bit t, input bit r = 1'b0);
    logic [27:0] got;
    start_pulse = s;
    lap_pulse   = l;
    tick_1hz    = t;
    rst_h       = r;
    model_step(s, l, t, r);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    got = {state_dbg, done, running, led, value1, value0};
    check_eq("sb", {4'h0, got}, {4'h0, exp_q.pop_front()});
    start_pulse = 1'b0;
    lap_pulse   = 1'b0;
    tick_1hz    = 1'b0;
    rst_h       = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // reset state
    step(0, 0, 0, 1);
    check_eq("rst_val", {value1, value0}, 8'h00);
    check_eq("rst_flags", {running, done, led}, 18'h0);
    check_eq("rst_state", state_dbg, ST_IDLE);

    // start then 12 ticks
    step(1, 0, 0);
    ticks(12);
    check_eq("t12_val", {value1, value0}, 8'h12);
    check_eq("t12_run", {running, led}, 17'h1_0001);

    // clear, then tick on the start edge is not counted; pause ignores ticks
    step(1, 0, 0);
    step(0, 1, 0);
    check_eq("lapclr_val", {value1, value0}, 8'h00);
    step(1, 0, 1);
    check_eq("start_tick", {value1, value0}, 8'h00);
    ticks(9);
    step(1, 0, 0);
    ticks(5);
    check_eq("pause_hold", {value1, value0}, 8'h09);
    step(1, 0, 0);
    ticks(1);
    check_eq("resume_10", {value1, value0}, 8'h10);

    // run to the limit
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    ticks(29);
    check_eq("pre_done", done, 1'b0);
    ticks(1);
    check_eq("done_val", {value1, value0}, 8'h30);
    check_eq("done_flags", {done, running, led}, 18'h2_FFFF);
    ticks(3);
    step(0, 1, 0);
    check_eq("done_holds", {value1, value0, done}, 9'h061);
    step(1, 0, 0);
    check_eq("done_to_idle", {value1, value0, 2'(state_dbg)}, 10'h000);

    // tick reaching the limit plus start: DONE wins
    step(1, 0, 0);
    ticks(29);
    step(1, 0, 1);
    check_eq("lim_start", {value1, value0, done}, 9'h061);
    step(1, 0, 0);

    // tick plus start below the limit: increment and pause
    step(1, 0, 0);
    ticks(5);
    step(1, 0, 1);
    check_eq("tick_start", {value1, value0, 2'(state_dbg)}, {8'h06, 2'(ST_PAUSE)});
    ticks(2);
    step(1, 0, 0);
    ticks(1);
    step(1, 0, 0);
    step(0, 1, 0);
    check_eq("pause_lap", {value1, value0, 2'(state_dbg)}, {8'h00, 2'(ST_IDLE)});
    step(0, 1, 0);

    // start and lap together in PAUSE: start wins
    step(1, 0, 0);
    ticks(2);
    step(1, 0, 0);
    step(1, 1, 0);
    check_eq("start_lap", {value1, value0, 2'(state_dbg)}, {8'h02, 2'(ST_RUN)});

    // lap in RUN
    ticks(2);
    step(0, 1, 0);
    ticks(3);
`ifdef STOPWATCH_LAP_EN
    check_eq("lap_hold", {value1, value0, led}, {8'h04, 16'h0003});
`else
    check_eq("lap_hold", {value1, value0, led}, {8'h07, 16'h0001});
`endif
    step(0, 1, 0);
    check_eq("lap_rel", {value1, value0, led}, {8'h07, 16'h0001});

    // mid-run reset at 15
    ticks(8);
    check_eq("pre_rst", {value1, value0}, 8'h15);
    step(1, 1, 1, 1);
    check_eq("mid_rst", {value1, value0, running, done, led, 2'(state_dbg)}, 28'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
    end

    check_eq("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
